// File: rtl/fp_mul_norm_round.sv
// Back end of the single-precision FP multiplier: captures the mantissa product on
// multiplier completion, then normalizes, rounds to nearest-even and packs the IEEE result.
module fp_mul_norm_round #(
  parameter int N    = 25,
  parameter int EW   = 8,
  parameter int BIAS = 127
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2*N-3:0]  prod,
  input  logic            mult_done,
  input  logic            abort,
  input  logic            sign_a,
  input  logic            sign_b,
  input  logic [EW-1:0]   exp_a,
  input  logic [EW-1:0]   exp_b,
  input  logic            zero_a,
  input  logic            zero_b,
  input  logic            inf_a,
  input  logic            inf_b,
  input  logic            nan_a,
  input  logic            nan_b,
  output logic [EW+N-2:0] result,
  output logic            result_valid,
  output logic            busy,
  output logic            overflow,
  output logic            underflow,
  output logic            inexact,
  output logic            invalid
);

  localparam int PW      = 2 * N - 2;
  localparam int FW      = N - 2;
  localparam int XW      = EW + 2;
  localparam int EXP_MAX = (1 << EW) - 1;
  localparam logic [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic [XW-1:0] ONE_X  = XW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [EW+N-2:0] pack(input logic s, input logic [EW-1:0] e,
                                           input logic [FW-1:0] f);
    return {s, e, f};
  endfunction

  state_t          state;
  logic            mult_done_q;

  // Operand snapshot taken at capture
  logic [PW-1:0]   prod_r;
  logic            sign_a_r, sign_b_r;
  logic [EW-1:0]   exp_a_r, exp_b_r;
  logic            zero_a_r, zero_b_r, inf_a_r, inf_b_r, nan_a_r, nan_b_r;

  // Normalized values (frac excludes the hidden bit, which is always 1 here)
  logic            sign_n;
  logic [XW-1:0]   exp_n;
  logic [FW-1:0]   frac_n;
  logic            guard_n, sticky_n;

  // Packed result waiting for the DONE cycle, so aborted ops never touch the outputs
  logic [EW+N-2:0] res_p;
  logic            ovf_p, unf_p, inx_p, inv_p;

  logic            capture;
  logic [XW-1:0]   exp_sum;
  logic [XW-1:0]   exp_norm_c;
  logic [FW-1:0]   frac_norm_c;
  logic            guard_c, sticky_c;

  logic            round_up;
  logic [FW:0]     frac_sum;
  logic [XW-1:0]   exp_rnd;
  logic [FW-1:0]   frac_rnd;
  logic [EW+N-2:0] res_c;
  logic            ovf_c, unf_c, inx_c, inv_c;
  logic            any_inf, any_zero;

  assign capture = mult_done & ~mult_done_q;

  // Normalization: a product in [2,4) shifts right one place and bumps the exponent
  always_comb begin
    exp_sum = {2'b00, exp_a_r} + {2'b00, exp_b_r} - BIAS_X;
    if (prod_r[PW-1]) begin
      exp_norm_c  = exp_sum + ONE_X;
      frac_norm_c = prod_r[PW-2 -: FW];
      guard_c     = prod_r[PW-2-FW];
      sticky_c    = |prod_r[PW-3-FW:0];
    end else begin
      exp_norm_c  = exp_sum;
      frac_norm_c = prod_r[PW-3 -: FW];
      guard_c     = prod_r[PW-3-FW];
      sticky_c    = |prod_r[PW-4-FW:0];
    end
  end

  // Round-to-nearest-even, exponent range checks and special-case selection
  always_comb begin
    round_up = guard_n & (sticky_n | frac_n[0]);
    frac_sum = {1'b0, frac_n} + {{FW{1'b0}}, round_up};
    if (frac_sum[FW]) begin
      exp_rnd  = exp_n + ONE_X;
      frac_rnd = {FW{1'b0}};
    end else begin
      exp_rnd  = exp_n;
      frac_rnd = frac_sum[FW-1:0];
    end

    any_inf  = inf_a_r | inf_b_r;
    any_zero = zero_a_r | zero_b_r;
    res_c    = {(EW+N-1){1'b0}};
    ovf_c    = 1'b0;
    unf_c    = 1'b0;
    inx_c    = 1'b0;
    inv_c    = 1'b0;

    if (nan_a_r | nan_b_r | (any_inf & any_zero)) begin
      res_c = pack(1'b0, {EW{1'b1}}, {1'b1, {(FW-1){1'b0}}});
      inv_c = 1'b1;
    end else if (any_inf) begin
      res_c = pack(sign_n, {EW{1'b1}}, {FW{1'b0}});
    end else if (any_zero) begin
      res_c = pack(sign_n, {EW{1'b0}}, {FW{1'b0}});
    end else if ($signed(exp_rnd) >= EXP_MAX) begin
      res_c = pack(sign_n, {EW{1'b1}}, {FW{1'b0}});
      ovf_c = 1'b1;
      inx_c = 1'b1;
    end else if ($signed(exp_rnd) <= 0) begin
      res_c = pack(sign_n, {EW{1'b0}}, {FW{1'b0}});
      unf_c = 1'b1;
      inx_c = 1'b1;
    end else begin
      res_c = pack(sign_n, exp_rnd[EW-1:0], frac_rnd);
      inx_c = guard_n | sticky_n;
    end
  end

  // Control FSM with all datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mult_done_q  <= 1'b0;
      prod_r       <= {PW{1'b0}};
      sign_a_r     <= 1'b0;
      sign_b_r     <= 1'b0;
      exp_a_r      <= {EW{1'b0}};
      exp_b_r      <= {EW{1'b0}};
      zero_a_r     <= 1'b0;
      zero_b_r     <= 1'b0;
      inf_a_r      <= 1'b0;
      inf_b_r      <= 1'b0;
      nan_a_r      <= 1'b0;
      nan_b_r      <= 1'b0;
      sign_n       <= 1'b0;
      exp_n        <= {XW{1'b0}};
      frac_n       <= {FW{1'b0}};
      guard_n      <= 1'b0;
      sticky_n     <= 1'b0;
      res_p        <= {(EW+N-1){1'b0}};
      ovf_p        <= 1'b0;
      unf_p        <= 1'b0;
      inx_p        <= 1'b0;
      inv_p        <= 1'b0;
      result       <= {(EW+N-1){1'b0}};
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      inexact      <= 1'b0;
      invalid      <= 1'b0;
    end else begin
      mult_done_q  <= mult_done;
      result_valid <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (capture) begin
              prod_r   <= prod;
              sign_a_r <= sign_a;
              sign_b_r <= sign_b;
              exp_a_r  <= exp_a;
              exp_b_r  <= exp_b;
              zero_a_r <= zero_a;
              zero_b_r <= zero_b;
              inf_a_r  <= inf_a;
              inf_b_r  <= inf_b;
              nan_a_r  <= nan_a;
              nan_b_r  <= nan_b;
              busy     <= 1'b1;
              state    <= NORM;
            end else begin
              state <= IDLE;
            end
          end
          NORM: begin
            sign_n   <= sign_a_r ^ sign_b_r;
            exp_n    <= exp_norm_c;
            frac_n   <= frac_norm_c;
            guard_n  <= guard_c;
            sticky_n <= sticky_c;
            state    <= ROUND;
          end
          ROUND: begin
            res_p <= res_c;
            ovf_p <= ovf_c;
            unf_p <= unf_c;
            inx_p <= inx_c;
            inv_p <= inv_c;
            state <= DONE;
          end
          DONE: begin
            result       <= res_p;
            overflow     <= ovf_p;
            underflow    <= unf_p;
            inexact      <= inx_p;
            invalid      <= inv_p;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Self-checking bench for fp_mul_norm_round: a table of hand-derived IEEE vectors
// checked through a scoreboard, plus abort, reset and held-done control sequences.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] prod;
  logic        mult_done, abort;
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [31:0] result;
  logic        result_valid, busy, overflow, underflow, inexact, invalid;

  int checks = 0;
  int errors = 0;
  int valid_count = 0;

  // {result, overflow, underflow, inexact, invalid}
  logic [35:0] expq[$];

  typedef struct {
    logic [47:0] prod;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [5:0]  sp;   // {zero_a, zero_b, inf_a, inf_b, nan_a, nan_b}
    logic [31:0] res;
    logic [3:0]  flg;  // {overflow, underflow, inexact, invalid}
  } vec_t;

  vec_t vecs[$];

  fp_mul_norm_round dut (
    .clk(clk), .reset(reset), .prod(prod), .mult_done(mult_done), .abort(abort),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .zero_a(zero_a), .zero_b(zero_b), .inf_a(inf_a), .inf_b(inf_b),
    .nan_a(nan_a), .nan_b(nan_b), .result(result), .result_valid(result_valid),
    .busy(busy), .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [47:0] p, logic sa, logic sb, logic [7:0] ea,
                              logic [7:0] eb, logic [5:0] sp, logic [31:0] r, logic [3:0] f);
    vec_t v;
    v.prod = p; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb; v.sp = sp; v.res = r; v.flg = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    prod = v.prod; sign_a = v.sa; sign_b = v.sb; exp_a = v.ea; exp_b = v.eb;
    {zero_a, zero_b, inf_a, inf_b, nan_a, nan_b} = v.sp;
    mult_done = 1'b1;
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      logic [35:0] e;
      valid_count++;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got result %h with nothing outstanding", result);
      end else begin
        e = expq.pop_front();
        if ({result, overflow, underflow, inexact, invalid} !== e) begin
          errors++;
          $display("FAIL result: got %h flags %b, expected %h flags %b",
                   result, {overflow, underflow, inexact, invalid}, e[35:4], e[3:0]);
        end
      end
    end
  end

  task automatic apply(input vec_t v, input int idx);
    int lat;
    logic got;
    @(negedge clk);
    drive(v);
    expq.push_back({v.res, v.flg});
    @(posedge clk); #1;
    check($sformatf("busy_after_capture[%0d]", idx), {63'd0, busy}, 64'd1);
    lat = 0;
    got = 1'b0;
    while (lat < 8 && !got) begin
      @(posedge clk); lat++; #1;
      got = result_valid;
    end
    check($sformatf("latency[%0d]", idx), {got, lat[31:0]}, {1'b1, 32'd3});
    @(negedge clk);
    mult_done = 1'b0;
    @(negedge clk);
    check($sformatf("busy_idle[%0d]", idx), {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int vc0;
    logic [31:0] last_res;
    reset = 1'b1; abort = 1'b0; mult_done = 1'b0;
    prod = 48'd0; sign_a = 1'b0; sign_b = 1'b0; exp_a = 8'd0; exp_b = 8'd0;
    {zero_a, zero_b, inf_a, inf_b, nan_a, nan_b} = 6'b000000;

    vecs.push_back(mk(48'h400000000000, 1'b0, 1'b0, 8'd127, 8'd127, 6'b000000, 32'h3F800000, 4'b0000));
    vecs.push_back(mk(48'h900000000000, 1'b0, 1'b1, 8'd127, 8'd127, 6'b000000, 32'hC0100000, 4'b0000));
    vecs.push_back(mk(48'h400000400000, 1'b0, 1'b0, 8'd127, 8'd127, 6'b000000, 32'h3F800000, 4'b0010));
    vecs.push_back(mk(48'h400000C00000, 1'b0, 1'b0, 8'd127, 8'd127, 6'b000000, 32'h3F800002, 4'b0010));
    vecs.push_back(mk(48'h7FFFFFC00000, 1'b0, 1'b0, 8'd127, 8'd127, 6'b000000, 32'h40000000, 4'b0010));
    vecs.push_back(mk(48'h7FFFFF800000, 1'b0, 1'b0, 8'd127, 8'd127, 6'b000000, 32'h3FFFFFFF, 4'b0000));
    vecs.push_back(mk(48'h800000800001, 1'b0, 1'b0, 8'd127, 8'd127, 6'b000000, 32'h40000001, 4'b0010));
    vecs.push_back(mk(48'h800000800000, 1'b0, 1'b0, 8'd127, 8'd127, 6'b000000, 32'h40000000, 4'b0010));
    vecs.push_back(mk(48'h400000000000, 1'b0, 1'b0, 8'd200, 8'd200, 6'b000000, 32'h7F800000, 4'b1010));
    vecs.push_back(mk(48'h400000000000, 1'b0, 1'b0, 8'd10,  8'd10,  6'b000000, 32'h00000000, 4'b0110));
    vecs.push_back(mk(48'h7FFFFFC00000, 1'b0, 1'b0, 8'd254, 8'd127, 6'b000000, 32'h7F800000, 4'b1010));
    vecs.push_back(mk(48'h400000000000, 1'b0, 1'b0, 8'd254, 8'd127, 6'b000000, 32'h7F000000, 4'b0000));
    vecs.push_back(mk(48'h400000000000, 1'b0, 1'b0, 8'd1,   8'd127, 6'b000000, 32'h00800000, 4'b0000));
    vecs.push_back(mk(48'h400000000000, 1'b0, 1'b0, 8'd1,   8'd126, 6'b000000, 32'h00000000, 4'b0110));
    vecs.push_back(mk(48'h800000000000, 1'b0, 1'b0, 8'd1,   8'd126, 6'b000000, 32'h00800000, 4'b0000));
    vecs.push_back(mk(48'h400000000000, 1'b1, 1'b0, 8'd127, 8'd127, 6'b011000, 32'h7FC00000, 4'b0001));
    vecs.push_back(mk(48'h400000000000, 1'b0, 1'b0, 8'd127, 8'd127, 6'b000001, 32'h7FC00000, 4'b0001));
    vecs.push_back(mk(48'h400000000000, 1'b1, 1'b0, 8'd127, 8'd127, 6'b001000, 32'hFF800000, 4'b0000));
    vecs.push_back(mk(48'h400000000000, 1'b0, 1'b1, 8'd127, 8'd127, 6'b100000, 32'h80000000, 4'b0000));

    repeat (2) @(negedge clk);
    check("reset_outputs", {24'd0, result, result_valid, busy, overflow, underflow, inexact, invalid},
          64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    last_res = vecs[vecs.size()-1].res;

    // Abort during NORM: no pulse, busy drops, outputs keep the previous result
    vc0 = valid_count;
    @(negedge clk); drive(vecs[1]);
    @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); abort = 1'b0; mult_done = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_valid", valid_count - vc0, 64'd0);
    check("abort_result_held", {32'd0, result}, {32'd0, last_res});

    // Abort coinciding with the done edge wins; the held level must not capture later
    vc0 = valid_count;
    @(negedge clk); drive(vecs[1]); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_capture_busy", {63'd0, busy}, 64'd0);
    check("abort_capture_no_valid", valid_count - vc0, 64'd0);
    mult_done = 1'b0;
    @(negedge clk);

    // Reset asserted while in ROUND clears everything at once
    vc0 = valid_count;
    @(negedge clk); drive(vecs[3]);
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b1; mult_done = 1'b0; #1;
    check("reset_mid_op", {24'd0, result, result_valid, busy, overflow, underflow, inexact, invalid},
          64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    check("reset_no_valid", valid_count - vc0, 64'd0);

    // mult_done held high for 10 cycles yields exactly one result
    vc0 = valid_count;
    @(negedge clk); drive(vecs[2]);
    expq.push_back({vecs[2].res, vecs[2].flg});
    repeat (10) @(negedge clk);
    mult_done = 1'b0;
    repeat (3) @(negedge clk);
    check("held_done_one_valid", valid_count - vc0, 64'd1);
    check("scoreboard_drained", expq.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
